// File: rtl/axi_rd_n_splitter.sv
// N-way AXI4 read-channel splitter.
// AR is decoded from an araddr field and forwarded to one slave port, or
// accepted locally when unmapped. A small FIFO records {dest, arid, arlen}
// in acceptance order so R beats go back to the master strictly in that order.
// Unmapped reads are answered by an internal DECERR responder.
module axi_rd_n_splitter #(
  parameter int AWID   = 32,
  parameter int IDWID  = 4,
  parameter int DWID   = 64,
  parameter int EXTRAS = 8,
  parameter int NSLV   = 4,
  parameter int SELLSB = 28,
  parameter int SELW   = 3,
  parameter int OUTS   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  // master AR
  input  logic [IDWID-1:0]         arid,
  input  logic [AWID-1:0]          araddr,
  input  logic [7:0]               arlen,
  input  logic [2:0]               arsize,
  input  logic [1:0]               arburst,
  input  logic [EXTRAS-1:0]        arextras,
  input  logic                     arvalid,
  output logic                     arready,
  // master R
  output logic [IDWID-1:0]         rid,
  output logic [DWID-1:0]          rdata,
  output logic [1:0]               rresp,
  output logic                     rlast,
  output logic                     rvalid,
  input  logic                     rready,
  // slave AR (payload broadcast to every slice)
  output logic [NSLV*IDWID-1:0]    s_arid,
  output logic [NSLV*AWID-1:0]     s_araddr,
  output logic [NSLV*8-1:0]        s_arlen,
  output logic [NSLV*3-1:0]        s_arsize,
  output logic [NSLV*2-1:0]        s_arburst,
  output logic [NSLV*EXTRAS-1:0]   s_arextras,
  output logic [NSLV-1:0]          s_arvalid,
  input  logic [NSLV-1:0]          s_arready,
  // slave R
  input  logic [NSLV*IDWID-1:0]    s_rid,
  input  logic [NSLV*DWID-1:0]     s_rdata,
  input  logic [NSLV*2-1:0]        s_rresp,
  input  logic [NSLV-1:0]          s_rlast,
  input  logic [NSLV-1:0]          s_rvalid,
  output logic [NSLV-1:0]          s_rready,
  // status
  output logic [$clog2(OUTS):0]    outstanding
);

  localparam int PTRW  = $clog2(OUTS);
  localparam int CNTW  = PTRW + 1;
  // dest code NSLV marks the internal DECERR target
  localparam int DESTW = $clog2(NSLV + 1);

  logic [SELW-1:0]  sel;
  logic             sel_mapped;
  logic [DESTW-1:0] push_dest;
  logic             slave_ready;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  logic [PTRW-1:0]  wr_ptr_reg;
  logic [PTRW-1:0]  rd_ptr_reg;
  logic [CNTW-1:0]  count_reg;
  logic [7:0]       beat_reg;

  logic [DESTW-1:0] dest_mem [OUTS];
  logic [IDWID-1:0] id_mem   [OUTS];
  logic [7:0]       len_mem  [OUTS];

  logic [DESTW-1:0] head_dest;
  logic [IDWID-1:0] head_id;
  logic [7:0]       head_len;
  logic             head_err;

  assign sel        = araddr[SELLSB+SELW-1:SELLSB];
  assign sel_mapped = int'(sel) < NSLV;
  assign push_dest  = sel_mapped ? DESTW'(sel) : DESTW'(NSLV);

  assign full  = (count_reg == CNTW'(OUTS));
  assign empty = (count_reg == '0);
  assign outstanding = count_reg;

  // Ready of the addressed slave; unmapped addresses are always accepted locally
  always_comb begin
    slave_ready = 1'b1;
    for (int k = 0; k < NSLV; k++) begin
      if (int'(sel) == k) slave_ready = s_arready[k];
    end
  end

  assign arready = !full && slave_ready;
  assign push    = arvalid && arready;

  // AR valid only to the decoded slave, never dependent on s_arready
  for (genvar gi = 0; gi < NSLV; gi++) begin : g_ar
    assign s_arvalid[gi]                   = arvalid && !full && (int'(sel) == gi);
    assign s_arid[gi*IDWID +: IDWID]       = arid;
    assign s_araddr[gi*AWID +: AWID]       = araddr;
    assign s_arlen[gi*8 +: 8]              = arlen;
    assign s_arsize[gi*3 +: 3]             = arsize;
    assign s_arburst[gi*2 +: 2]            = arburst;
    assign s_arextras[gi*EXTRAS +: EXTRAS] = arextras;
  end

  // FIFO storage write; head is read combinationally so R has no added latency
  always_ff @(posedge clk) begin
    if (push) begin
      dest_mem[wr_ptr_reg] <= push_dest;
      id_mem[wr_ptr_reg]   <= arid;
      len_mem[wr_ptr_reg]  <= arlen;
    end
  end

  assign head_dest = dest_mem[rd_ptr_reg];
  assign head_id   = id_mem[rd_ptr_reg];
  assign head_len  = len_mem[rd_ptr_reg];
  assign head_err  = (int'(head_dest) == NSLV);

  // R routing from the FIFO head; everything idles to zero when nothing is outstanding
  always_comb begin
    rvalid   = 1'b0;
    rid      = '0;
    rdata    = '0;
    rresp    = '0;
    rlast    = 1'b0;
    s_rready = '0;
    if (!empty) begin
      if (head_err) begin
        rvalid = 1'b1;
        rid    = head_id;
        rresp  = 2'b11;
        rlast  = (beat_reg == head_len);
      end else begin
        for (int k = 0; k < NSLV; k++) begin
          if (int'(head_dest) == k) begin
            rvalid      = s_rvalid[k];
            rid         = s_rid[k*IDWID +: IDWID];
            rdata       = s_rdata[k*DWID +: DWID];
            rresp       = s_rresp[k*2 +: 2];
            rlast       = s_rlast[k];
            s_rready[k] = rready;
          end
        end
      end
    end
  end

  assign pop = rvalid && rready && rlast;

  // Pointers and occupancy; pointers wrap naturally since OUTS is a power of 2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTRW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTRW'(1);
      count_reg <= count_reg + CNTW'(push) - CNTW'(pop);
    end
  end

  // DECERR beat counter: advances per accepted responder beat, clears on the last one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_reg <= '0;
    end else if (!empty && head_err && rready) begin
      beat_reg <= rlast ? 8'd0 : beat_reg + 8'd1;
    end
  end

endmodule

// File: doc/axi_rd_n_splitter.md
# axi_rd_n_splitter

Parametrised N-way AXI4 read-channel splitter with in-order response routing and built-in decode-error responder. Sits between one AXI read master and NSLV slave read ports in the NoC. AR is routed by an address field; R beats are returned strictly in AR-acceptance order via an outstanding-destination FIFO. Unmapped addresses get an internal DECERR response; nothing is dropped or hung.

## Interface
- AWID, 32, address width
- IDWID, 4, ID width
- DWID, 64, data width
- EXTRAS, 8, sideband width carried with AR
- NSLV, 4, number of slave ports (1..2**SELW)
- SELLSB, 28, LSB of the decode field in araddr
- SELW, 3, decode field width; sel = araddr[SELLSB+SELW-1:SELLSB]
- OUTS, 8, outstanding-burst FIFO depth (power of 2, >=2)

Ports (k-th slave occupies slice [k*W +: W] of each flattened bus):
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- arid/araddr/arlen/arsize/arburst/arextras  in  IDWID/AWID/8/3/2/EXTRAS  master AR payload
- arvalid  in  1;  arready  out  1
- rid/rdata/rresp/rlast  out  IDWID/DWID/2/1  master R payload
- rvalid  out  1;  rready  in  1
- s_arid/s_araddr/s_arlen/s_arsize/s_arburst/s_arextras  out  NSLV×(IDWID/AWID/8/3/2/EXTRAS)  AR payload, broadcast to all slices
- s_arvalid  out  NSLV;  s_arready  in  NSLV
- s_rid/s_rdata/s_rresp/s_rlast  in  NSLV×(IDWID/DWID/2/1)
- s_rvalid  in  NSLV;  s_rready  out  NSLV
- outstanding  out  $clog2(OUTS)+1  current FIFO occupancy

## Operation
- Decode: sel<NSLV → slave sel; sel>=NSLV → DECERR target (dest code NSLV).
- FIFO entry = {dest, arid, arlen}. Push on arvalid&&arready.
- AR: s_arvalid[k] = arvalid && !full && sel==k. arready = !full && (sel<NSLV ? s_arready[sel] : 1). DECERR AR accepted without slave contact.
- R, head dest<NSLV: rvalid=s_rvalid[dest], payload muxed from that slice; s_rready[dest]=rready; all other s_rready=0.
- R, head dest==NSLV: responder drives rvalid=1, rid=stored arid, rdata=0, rresp=2'b11, rlast=(beat==stored arlen). 8-bit beat counter increments per handshake, clears on last.
- Pop on rvalid&&rready&&rlast. Slave beats with rlast=0 never pop.
- Empty FIFO: rvalid=0, all s_rready=0; slave R traffic back-pressured.
- Full: arready=0, all s_arvalid=0. Push and pop same cycle when not full: occupancy unchanged. Push while full never occurs (no bypass).
- rid from slave passes through unchanged; no ID remapping, no reordering across slaves.
- Pointers wrap modulo OUTS; occupancy counter distinguishes full/empty.

## Timing
- Reset (async assert, sync-free deassert): FIFO empty, pointers/occupancy/beat counter 0. Outputs after reset: arready = s_arready[sel] or 1 for DECERR (combinational, FIFO not full), rvalid=0, rlast=0, rresp=0, rdata=0, rid=0, s_arvalid follows arvalid, s_rready=0, outstanding=0.
- AR path combinational, 0-cycle latency; s_arvalid never depends on s_arready.
- R path combinational, 0-cycle; first R beat of a burst may be presented the cycle after its AR push (FIFO write visible next cycle).
- DECERR burst of arlen+1 beats takes arlen+1 cycles with rready held high.
- Reset mid-burst: FIFO and counter cleared immediately; in-flight slave beats are the system's responsibility (slaves reset together).

## Test plan
- Single read araddr=0x1000_0000, arlen=3, arid=5 → s_arvalid[1] only; 4 beats from slave 1 return rid=5, rlast on 4th; outstanding 0→1→0.
- Interleaved ARs to slave 2 then slave 0 (arlen=1 each); slave 0 answers first → slave 0 held (s_rready[0]=0) until slave 2 burst completes; master sees slave 2 data first.
- araddr=0x5000_0000 (sel=5), arlen=2, arid=9 → no s_arvalid; 3 beats rresp=2'b11, rdata=0, rid=9, rlast on 3rd.
- Issue OUTS=8 ARs with no R returns → outstanding=8, arready=0, all s_arvalid=0; one rlast handshake → arready reasserts next cycle.
- Same-cycle push and last-beat pop at outstanding=3 → stays 3; pointer wrap after 20 bursts, ordering intact.
- Assert rst_n=0 mid-DECERR burst → rvalid=0 and outstanding=0 immediately; fresh AR after release works normally.
